// File: rtl/zebra_frame_filter.sv
// Frame-level vote on a per-pixel zebra flag stream, with an ON/OFF hysteresis
// debounce and a single-entry result register that overwrites when full.
module zebra_frame_filter #(
  parameter int IMG_WIDTH      = 320,
  parameter int IMG_HEIGHT     = 240,
  parameter int VOTE_THRESHOLD = (IMG_WIDTH * IMG_HEIGHT) / 2,
  parameter int ON_FRAMES      = 3,
  parameter int OFF_FRAMES     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        x_valid,
  output logic        x_ready,
  input  logic        x_data,
  output logic        y_valid,
  input  logic        y_ready,
  output logic        y_data,
  output logic        y_raw,
  output logic        dropped,
  output logic [15:0] frame_count,
  output logic [1:0]  state_debug
);

  // state         | meaning
  // S_CLEAR       | no zebra, waiting for a first zebra frame
  // S_PENDING_ON  | counting consecutive zebra frames towards ON_FRAMES
  // S_ASSERTED    | zebra reported
  // S_PENDING_OFF | counting consecutive non-zebra frames towards OFF_FRAMES
  typedef enum logic [1:0] {
    S_CLEAR       = 2'd0,
    S_PENDING_ON  = 2'd1,
    S_ASSERTED    = 2'd2,
    S_PENDING_OFF = 2'd3
  } state_t;

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int VW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);

  localparam logic [XW-1:0] X_LAST   = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMG_HEIGHT - 1);
  localparam logic [31:0]   THRESH   = 32'(VOTE_THRESHOLD);
  localparam logic [3:0]    ON_CNT   = 4'(ON_FRAMES);
  localparam logic [3:0]    OFF_CNT  = 4'(OFF_FRAMES);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [VW-1:0] r_vote;
  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [15:0]   r_frame_count;
  logic          r_y_valid;
  logic          r_y_data;
  logic          r_y_raw;
  logic          r_dropped;

  logic          w_hs;
  logic          w_frame_end;
  logic [VW-1:0] w_vote_sum;
  logic          w_raw;
  state_t        w_state_next;
  logic [3:0]    w_cnt_next;
  logic          w_decision_next;
  logic [3:0]    w_cnt_inc;

  assign x_ready     = 1'b1;
  assign w_hs        = x_valid & x_ready;
  assign w_frame_end = w_hs && (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_vote_sum  = r_vote + VW'(x_data);
  assign w_raw       = 32'(w_vote_sum) >= THRESH;
  assign w_cnt_inc   = r_cnt + 4'd1;

  // Raster position and vote accumulation; the last pixel is counted into the vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_vote <= '0;
    end else if (w_hs) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
      r_vote <= w_frame_end ? '0 : w_vote_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (w_frame_end) begin
      case (r_state)
        S_CLEAR: begin
          if (w_raw) begin
            if (ON_CNT == 4'd1) begin
              w_state_next = S_ASSERTED;
              w_cnt_next   = 4'd0;
            end else begin
              w_state_next = S_PENDING_ON;
              w_cnt_next   = 4'd1;
            end
          end
        end
        S_PENDING_ON: begin
          if (!w_raw) begin
            w_state_next = S_CLEAR;
            w_cnt_next   = 4'd0;
          end else if (w_cnt_inc == ON_CNT) begin
            w_state_next = S_ASSERTED;
            w_cnt_next   = 4'd0;
          end else begin
            w_cnt_next   = w_cnt_inc;
          end
        end
        S_ASSERTED: begin
          if (!w_raw) begin
            if (OFF_CNT == 4'd1) begin
              w_state_next = S_CLEAR;
              w_cnt_next   = 4'd0;
            end else begin
              w_state_next = S_PENDING_OFF;
              w_cnt_next   = 4'd1;
            end
          end
        end
        S_PENDING_OFF: begin
          if (w_raw) begin
            w_state_next = S_ASSERTED;
            w_cnt_next   = 4'd0;
          end else if (w_cnt_inc == OFF_CNT) begin
            w_state_next = S_CLEAR;
            w_cnt_next   = 4'd0;
          end else begin
            w_cnt_next   = w_cnt_inc;
          end
        end
        default: begin
          w_state_next = S_CLEAR;
          w_cnt_next   = 4'd0;
        end
      endcase
    end
  end

  // The reported decision is taken from the state the frame moves us into.
  always_comb begin
    w_decision_next = (w_state_next == S_ASSERTED) || (w_state_next == S_PENDING_OFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_valid     <= 1'b0;
      r_y_data      <= 1'b0;
      r_y_raw       <= 1'b0;
      r_dropped     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_dropped <= 1'b0;
      if (w_frame_end) begin
        r_y_valid     <= 1'b1;
        r_y_data      <= w_decision_next;
        r_y_raw       <= w_raw;
        r_dropped     <= r_y_valid && !y_ready;
        r_frame_count <= r_frame_count + 16'd1;
      end else if (r_y_valid && y_ready) begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign y_valid     = r_y_valid;
  assign y_data      = r_y_data;
  assign y_raw       = r_y_raw;
  assign dropped     = r_dropped;
  assign frame_count = r_frame_count;
  assign state_debug = r_state;

endmodule

// File: tb/tb_zebra_frame_filter.sv
// Bench for zebra_frame_filter: directed literal scenarios plus randomized frames,
// gaps and back-pressure, checked every cycle against a frame-level reference model.
module tb_zebra_frame_filter;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int THR = 4;
  localparam int ON  = 3;
  localparam int OFF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        x_valid = 1'b0;
  logic        x_data = 1'b0;
  logic        y_ready = 1'b1;
  logic        x_ready;
  logic        y_valid;
  logic        y_data;
  logic        y_raw;
  logic        dropped;
  logic [15:0] frame_count;
  logic [1:0]  state_debug;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_ready = 1'b0;
  int gap_pct = 0;

  zebra_frame_filter #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .VOTE_THRESHOLD(THR),
    .ON_FRAMES(ON), .OFF_FRAMES(OFF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_raw(y_raw),
    .dropped(dropped), .frame_count(frame_count), .state_debug(state_debug)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decision d plus a run length of frames disagreeing with d.
  int          m_pix, m_votes, m_streak;
  bit          m_d, m_yv, m_yd, m_yr, m_drop;
  logic [15:0] m_fc;

  function automatic logic [1:0] m_state();
    if (m_d) return (m_streak != 0) ? 2'd3 : 2'd2;
    else     return (m_streak != 0) ? 2'd1 : 2'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pix = 0; m_votes = 0; m_streak = 0; m_d = 0;
      m_yv = 0; m_yd = 0; m_yr = 0; m_drop = 0; m_fc = 0;
    end else begin
      bit consumed, fend, raw;
      consumed = m_yv && y_ready;
      fend = 0;
      m_drop = 0;
      if (x_valid) begin
        m_votes += int'(x_data);
        m_pix++;
        if (m_pix == W * H) begin
          fend = 1;
          raw = (m_votes >= THR);
          m_pix = 0;
          m_votes = 0;
          if (raw != m_d) begin
            m_streak++;
            if (m_streak == (raw ? ON : OFF)) begin
              m_d = raw;
              m_streak = 0;
            end
          end else begin
            m_streak = 0;
          end
          m_fc++;
          m_drop = m_yv && !y_ready;
          m_yv = 1; m_yd = m_d; m_yr = raw;
        end
      end
      if (!fend && consumed) m_yv = 0;
    end
  end

  always @(negedge clk) begin
    check("x_ready",     32'(x_ready),     32'd1);
    check("y_valid",     32'(y_valid),     32'(m_yv));
    check("y_data",      32'(y_data),      32'(m_yd));
    check("y_raw",       32'(y_raw),       32'(m_yr));
    check("dropped",     32'(dropped),     32'(m_drop));
    check("frame_count", 32'(frame_count), 32'(m_fc));
    check("state_debug", 32'(state_debug), 32'(m_state()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) y_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pixel(input bit b);
    while (int'($urandom_range(0, 99)) < gap_pct) begin
      x_valid = 1'b0;
      x_data = 1'($urandom_range(0, 1));
      tick();
    end
    x_valid = 1'b1;
    x_data = b;
    tick();
    x_valid = 1'b0;
    x_data = 1'b0;
  endtask

  task automatic frame(input logic [7:0] bits);
    logic [7:0] v;
    v = bits;
    for (int i = 0; i < W * H; i++) pixel(v[i]);
  endtask

  task automatic lit(input string name, input bit raw_e, input bit data_e, input logic [1:0] sd_e);
    check({name, ".y_valid"},     32'(y_valid),     32'd1);
    check({name, ".y_raw"},       32'(y_raw),       32'(raw_e));
    check({name, ".y_data"},      32'(y_data),      32'(data_e));
    check({name, ".state_debug"}, 32'(state_debug), 32'(sd_e));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    do_reset();
    tick();
    check("idle.y_valid", 32'(y_valid), 32'd0);
    check("idle.y_data", 32'(y_data), 32'd0);
    check("idle.y_raw", 32'(y_raw), 32'd0);
    check("idle.dropped", 32'(dropped), 32'd0);
    check("idle.frame_count", 32'(frame_count), 32'd0);
    check("idle.state_debug", 32'(state_debug), 32'd0);
    check("idle.x_ready", 32'(x_ready), 32'd1);

    y_ready = 1'b1;
    frame(8'hFF); lit("on1", 1, 0, 2'd1);
    frame(8'hFF); lit("on2", 1, 0, 2'd1);
    frame(8'hFF); lit("on3", 1, 1, 2'd2);
    check("on.frame_count", 32'(frame_count), 32'd3);

    frame(8'h00); lit("off1", 0, 1, 2'd3);
    frame(8'hFF); lit("off2", 1, 1, 2'd2);
    frame(8'h00); lit("off3", 0, 1, 2'd3);
    frame(8'h00); lit("off4", 0, 0, 2'd0);

    frame(8'h0F); lit("thr4", 1, 0, 2'd1);
    frame(8'h07); lit("thr3", 0, 0, 2'd0);
    gap_pct = 40;
    frame(8'hB4); lit("gap4", 1, 0, 2'd1);
    frame(8'h70); lit("gap3", 0, 0, 2'd0);
    gap_pct = 0;
    check("thr.frame_count", 32'(frame_count), 32'd11);

    do_reset();
    y_ready = 1'b0;
    frame(8'hFF); lit("bp1", 1, 0, 2'd1);
    check("bp1.dropped", 32'(dropped), 32'd0);
    tick(); tick();
    frame(8'h00); lit("bp2", 0, 0, 2'd0);
    check("bp2.dropped", 32'(dropped), 32'd1);
    check("bp2.frame_count", 32'(frame_count), 32'd2);
    tick();
    check("bp.dropped_pulse", 32'(dropped), 32'd0);
    check("bp.held_valid", 32'(y_valid), 32'd1);
    y_ready = 1'b1;
    tick();
    check("bp.consumed", 32'(y_valid), 32'd0);

    y_ready = 1'b0;
    frame(8'hFF); lit("sim1", 1, 0, 2'd1);
    for (int i = 0; i < W * H - 1; i++) pixel(1'b1);
    y_ready = 1'b1;
    pixel(1'b1);
    lit("sim2", 1, 0, 2'd1);
    check("sim2.dropped", 32'(dropped), 32'd0);
    tick();
    check("sim2.consumed", 32'(y_valid), 32'd0);

    y_ready = 1'b0;
    frame(8'hFF);
    for (int i = 0; i < 5; i++) pixel(1'b1);
    rst_n = 1'b0;
    #1;
    check("rst.y_valid", 32'(y_valid), 32'd0);
    check("rst.frame_count", 32'(frame_count), 32'd0);
    check("rst.state_debug", 32'(state_debug), 32'd0);
    check("rst.y_data", 32'(y_data), 32'd0);
    check("rst.x_ready", 32'(x_ready), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    y_ready = 1'b1;
    frame(8'hFF); lit("rst1", 1, 0, 2'd1);
    check("rst1.frame_count", 32'(frame_count), 32'd1);

    rand_ready = 1'b1;
    gap_pct = 20;
    for (int f = 0; f < 300; f++) begin
      frame(8'($urandom));
      if (f == 150) begin
        for (int i = 0; i < 3; i++) pixel(1'($urandom_range(0, 1)));
        do_reset();
      end
    end
    rand_ready = 1'b0;
    y_ready = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/zebra_frame_filter.md
ZEBRA_FRAME_FILTER -- requirements
Module: zebra_frame_filter

Interface
REQ-001 Parameter IMG_WIDTH, default 320, pixels per line of the incoming detection stream.
REQ-002 Parameter IMG_HEIGHT, default 240, lines per frame.
REQ-003 Parameter VOTE_THRESHOLD, default (IMG_WIDTH*IMG_HEIGHT)/2, minimum count of 1-pixels for a frame to vote "zebra".
REQ-004 Parameter ON_FRAMES, default 3, consecutive zebra frames required to assert; legal range 1..15.
REQ-005 Parameter OFF_FRAMES, default 5, consecutive non-zebra frames required to deassert; legal range 1..15.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 x_valid  input  1  detection pixel valid from zebra_crossing_detector.
REQ-009 x_ready  output  1  input ready; constant 1 (stage never stalls).
REQ-010 x_data  input  1  per-pixel zebra flag.
REQ-011 y_valid  output  1  per-frame result valid.
REQ-012 y_ready  input  1  consumer ready.
REQ-013 y_data  output  1  debounced (hysteresis) zebra decision.
REQ-014 y_raw  output  1  that frame's un-debounced vote.
REQ-015 dropped  output  1  one-cycle pulse: unconsumed result overwritten.
REQ-016 frame_count  output  16  frames completed since reset, wraps 0xFFFF->0.
REQ-017 state_debug  output  2  hysteresis FSM state encoding.

Function
REQ-018 Handshake = x_valid && x_ready; only handshake cycles advance pixel position or vote count; x_valid low cycles (gaps) change nothing.
REQ-019 Pixel position x (0..IMG_WIDTH-1) and y (0..IMG_HEIGHT-1) shall advance raster order per handshake, x wrapping to 0 and incrementing y, y wrapping to 0 after last line.
REQ-020 Vote counter shall add x_data per handshake; width $clog2(IMG_WIDTH*IMG_HEIGHT+1), no saturation needed.
REQ-021 On handshake of last pixel (x=IMG_WIDTH-1, y=IMG_HEIGHT-1): raw = (vote count including this pixel >= VOTE_THRESHOLD); vote counter cleared to 0 on same edge.
REQ-022 FSM states: CLEAR=0, PENDING_ON=1, ASSERTED=2, PENDING_OFF=3, with consecutive-frame counter cnt; updated only at frame end using raw.
REQ-023 CLEAR: raw=1 -> ASSERTED if ON_FRAMES==1, else PENDING_ON with cnt=1; raw=0 -> stay.
REQ-024 PENDING_ON: raw=1 -> cnt+1, entering ASSERTED (cnt=0) when cnt+1==ON_FRAMES; raw=0 -> CLEAR, cnt=0.
REQ-025 ASSERTED: raw=0 -> CLEAR if OFF_FRAMES==1, else PENDING_OFF with cnt=1; raw=1 -> stay.
REQ-026 PENDING_OFF: raw=0 -> cnt+1, entering CLEAR (cnt=0) when cnt+1==OFF_FRAMES; raw=1 -> ASSERTED, cnt=0.
REQ-027 Debounced decision = 1 in ASSERTED or PENDING_OFF, else 0, evaluated on the post-update state.
REQ-028 Latency: cycle after last-pixel handshake, y_valid=1, y_data=post-update decision, y_raw=raw, frame_count incremented.
REQ-029 Output register is single-entry: y_valid stays 1 with y_data/y_raw stable until y_valid && y_ready, then clears next cycle.
REQ-030 Frame end while y_valid=1 and y_ready=0: new result overwrites register, y_valid stays 1, dropped pulses 1 for one cycle.
REQ-031 Frame end in same cycle as y_valid && y_ready: new result loaded, y_valid stays 1, no dropped pulse.
REQ-032 FSM, counters and frame_count shall update regardless of y_ready.
REQ-033 state_debug shall reflect current FSM state each cycle.

Reset
REQ-034 rst_n low asynchronously clears x, y, vote counter, cnt, frame_count to 0, FSM to CLEAR, y_valid/y_data/y_raw/dropped to 0; x_ready remains 1.
REQ-035 Reset mid-frame discards partial frame; first frame after release starts at pixel (0,0).

Verification (IMG_WIDTH=4, IMG_HEIGHT=2, VOTE_THRESHOLD=4, ON_FRAMES=3, OFF_FRAMES=2)
REQ-036 Reset then idle -> all outputs 0, x_ready=1, state_debug=0.
REQ-037 Three all-ones frames, y_ready=1 -> results (y_raw,y_data) = (1,0),(1,0),(1,1); state_debug 1,1,2; frame_count=3.
REQ-038 Frame with exactly 4 ones -> y_raw=1; frame with 3 ones -> y_raw=0; random x_valid gaps give identical results.
REQ-039 From ASSERTED: frames 0,1,0,0 -> y_data 1,1,1,0; state_debug 3,2,3,0.
REQ-040 y_ready=0 across two frame ends -> one dropped pulse at second result; held result equals second frame's; frame_count=2.
REQ-041 rst_n asserted after 5 pixels of a frame -> outputs cleared immediately; next full all-ones frame yields y_raw=1, frame_count=1.
